// File: rtl/arbitro_mux_n.sv
// rtl/arbitro_mux_n.sv - N-channel VC arbiter and registered output mux.
// Define ARB_MUX_RR_EN for burst-limited round-robin; default is strict priority.
module arbitro_mux_n #(
  parameter int NUM_VC = 2,
  parameter int DATA_W = 6,
  parameter int BURST  = 4
) (
  input  logic                     clk,
  input  logic                     reset_L,
  input  logic [NUM_VC*DATA_W-1:0] vc_data,
  input  logic [NUM_VC-1:0]        vc_empty,
  input  logic                     pause,
  output logic [NUM_VC-1:0]        vc_pop,
  output logic [DATA_W-1:0]        arb_data,
  output logic                     arb_valid,
  output logic [((NUM_VC > 2) ? $clog2(NUM_VC) : 1)-1:0] grant_idx
);

  localparam int IDX_W = (NUM_VC > 2) ? $clog2(NUM_VC) : 1;

  logic [NUM_VC-1:0] elig;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  win;
  logic [IDX_W:0]    cand;
  logic              found;
  logic [DATA_W-1:0] sel_data;

  assign elig = ~vc_empty & {NUM_VC{~pause & reset_L}};

  // Search upward from ptr with wrap; cand never exceeds 2*NUM_VC-2 so one subtract suffices.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_VC; k++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_VC)) begin
        cand = cand - (IDX_W+1)'(NUM_VC);
      end
      if (!found && elig[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        win   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    vc_pop   = '0;
    sel_data = '0;
    if (found) begin
      vc_pop[win] = 1'b1;
    end
    for (int k = 0; k < NUM_VC; k++) begin
      if (win == IDX_W'(k)) begin
        sel_data = vc_data[k*DATA_W +: DATA_W];
      end
    end
  end

`ifdef ARB_MUX_RR_EN
  localparam int CNT_W = (BURST > 1) ? $clog2(BURST+1) : 1;

  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] win_next;

  assign win_next = (win == IDX_W'(NUM_VC-1)) ? '0 : win + 1'b1;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      ptr <= '0;
      cnt <= '0;
    end else if (found) begin
      if (win == ptr) begin
        if (int'(cnt) + 1 < BURST) begin
          cnt <= cnt + 1'b1;
        end else begin
          ptr <= win_next;
          cnt <= '0;
        end
      end else if (BURST == 1) begin
        ptr <= win_next;
        cnt <= '0;
      end else begin
        // ptr channel was empty: the burst restarts on the channel actually served
        ptr <= win;
        cnt <= CNT_W'(1);
      end
    end
  end
`else
  assign ptr = '0;
`endif

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      arb_data  <= '0;
      arb_valid <= 1'b0;
      grant_idx <= '0;
    end else if (found) begin
      arb_data  <= sel_data;
      arb_valid <= 1'b1;
      grant_idx <= win;
    end else begin
      arb_valid <= 1'b0;
    end
  end

endmodule
